// File: rtl/ctrl_rx_cmd_decoder.sv
// Receive-side command decoder: turns framed UART RX bytes into register-file and ALU strobes.
// Optional inter-byte timeout abort is enabled by defining CMD_TIMEOUT_EN.
module ctrl_rx_cmd_decoder #(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  RX_P_DATA,
  input  logic              RX_D_VLD,
  output logic              WrEn,
  output logic              RdEn,
  output logic [ADDR_W-1:0] Address,
  output logic [WIDTH-1:0]  WrData,
  output logic [3:0]        ALU_FUN,
  output logic              ALU_EN,
  output logic              CLK_GATE_EN,
  output logic              enable_alu,
  output logic              enable_reg,
  output logic              CMD_ERR
);

  localparam logic [WIDTH-1:0] OP_WR      = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] OP_RD      = WIDTH'(8'hBB);
  localparam logic [WIDTH-1:0] OP_ALU_OPS = WIDTH'(8'hCC);
  localparam logic [WIDTH-1:0] OP_ALU_FN  = WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_ALU_OPA = 3'd4,
    ST_ALU_OPB = 3'd5,
    ST_ALU_FN  = 3'd6
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   addr_lat_r;
  logic [ADDR_W-1:0]   addr_lat_nxt_s;
  logic                wr_en_nxt_s;
  logic                rd_en_nxt_s;
  logic                alu_en_nxt_s;
  logic                cmd_err_nxt_s;
  logic                gate_nxt_s;
  logic [ADDR_W-1:0]   address_nxt_s;
  logic [WIDTH-1:0]    wr_data_nxt_s;
  logic [3:0]          alu_fun_nxt_s;

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt_r;
  logic [CNT_W-1:0] tmo_cnt_nxt_s;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // Next-state and next-output decode; payload bytes are never compared against opcodes.
  always_comb begin
    state_nxt_s    = state_r;
    addr_lat_nxt_s = addr_lat_r;
    wr_en_nxt_s    = 1'b0;
    rd_en_nxt_s    = 1'b0;
    alu_en_nxt_s   = 1'b0;
    cmd_err_nxt_s  = 1'b0;
    address_nxt_s  = Address;
    wr_data_nxt_s  = WrData;
    alu_fun_nxt_s  = ALU_FUN;
`ifdef CMD_TIMEOUT_EN
    tmo_cnt_nxt_s  = tmo_cnt_r;
`endif

    if (RX_D_VLD) begin
`ifdef CMD_TIMEOUT_EN
      tmo_cnt_nxt_s = {CNT_W{1'b0}};
`endif
      case (state_r)
        ST_IDLE: begin
          case (RX_P_DATA)
            OP_WR:      state_nxt_s = ST_WR_ADDR;
            OP_RD:      state_nxt_s = ST_RD_ADDR;
            OP_ALU_OPS: state_nxt_s = ST_ALU_OPA;
            OP_ALU_FN:  state_nxt_s = ST_ALU_FN;
            default:    cmd_err_nxt_s = 1'b1;
          endcase
        end
        ST_WR_ADDR: begin
          addr_lat_nxt_s = RX_P_DATA[ADDR_W-1:0];
          state_nxt_s    = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          wr_en_nxt_s   = 1'b1;
          address_nxt_s = addr_lat_r;
          wr_data_nxt_s = RX_P_DATA;
          state_nxt_s   = ST_IDLE;
        end
        ST_RD_ADDR: begin
          rd_en_nxt_s   = 1'b1;
          address_nxt_s = RX_P_DATA[ADDR_W-1:0];
          state_nxt_s   = ST_IDLE;
        end
        ST_ALU_OPA: begin
          wr_en_nxt_s   = 1'b1;
          address_nxt_s = {ADDR_W{1'b0}};
          wr_data_nxt_s = RX_P_DATA;
          state_nxt_s   = ST_ALU_OPB;
        end
        ST_ALU_OPB: begin
          wr_en_nxt_s   = 1'b1;
          address_nxt_s = ADDR_W'(1'b1);
          wr_data_nxt_s = RX_P_DATA;
          state_nxt_s   = ST_ALU_FN;
        end
        ST_ALU_FN: begin
          alu_en_nxt_s  = 1'b1;
          alu_fun_nxt_s = RX_P_DATA[3:0];
          state_nxt_s   = ST_IDLE;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
`ifdef CMD_TIMEOUT_EN
      // A byte in the expiry cycle takes the branch above, so it always beats the abort.
      if (state_r == ST_IDLE) begin
        tmo_cnt_nxt_s = {CNT_W{1'b0}};
      end else if (tmo_cnt_r == TMO_LAST) begin
        state_nxt_s   = ST_IDLE;
        cmd_err_nxt_s = 1'b1;
        tmo_cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
        tmo_cnt_nxt_s = tmo_cnt_r + CNT_W'(1'b1);
      end
`else
      state_nxt_s = state_r;
`endif
    end

    gate_nxt_s = (state_nxt_s == ST_ALU_OPA) || (state_nxt_s == ST_ALU_OPB) ||
                 (state_nxt_s == ST_ALU_FN)  || alu_en_nxt_s;
  end

  // State, latched address and all registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_IDLE;
      addr_lat_r  <= {ADDR_W{1'b0}};
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      Address     <= {ADDR_W{1'b0}};
      WrData      <= {WIDTH{1'b0}};
      ALU_FUN     <= 4'h0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      enable_alu  <= 1'b0;
      enable_reg  <= 1'b0;
      CMD_ERR     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      addr_lat_r  <= addr_lat_nxt_s;
      WrEn        <= wr_en_nxt_s;
      RdEn        <= rd_en_nxt_s;
      Address     <= address_nxt_s;
      WrData      <= wr_data_nxt_s;
      ALU_FUN     <= alu_fun_nxt_s;
      ALU_EN      <= alu_en_nxt_s;
      CLK_GATE_EN <= gate_nxt_s;
      enable_alu  <= alu_en_nxt_s;
      enable_reg  <= rd_en_nxt_s;
      CMD_ERR     <= cmd_err_nxt_s;
    end
  end

`ifdef CMD_TIMEOUT_EN
  // Inter-byte timeout counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_nxt_s;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_rx_cmd_decoder.sv
// Directed scoreboard bench for ctrl_rx_cmd_decoder; strobe cycles are popped from an expectation queue.
// Covers both builds (CMD_TIMEOUT_EN defined or not) with TIMEOUT_CYC=16.
module tb_ctrl_rx_cmd_decoder;

  localparam int WIDTH       = 8;
  localparam int ADDR_W      = 4;
  localparam int TIMEOUT_CYC = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [WIDTH-1:0]  RX_P_DATA = 8'h00;
  logic              RX_D_VLD = 1'b0;
  logic              WrEn, RdEn, ALU_EN, CLK_GATE_EN, enable_alu, enable_reg, CMD_ERR;
  logic [ADDR_W-1:0] Address;
  logic [WIDTH-1:0]  WrData;
  logic [3:0]        ALU_FUN;

  ctrl_rx_cmd_decoder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData), .ALU_FUN(ALU_FUN),
    .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN), .enable_alu(enable_alu),
    .enable_reg(enable_reg), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_asserts = 0;
  int n_fails   = 0;

  // {WrEn,RdEn,ALU_EN,enable_alu,enable_reg,CMD_ERR,Address,WrData,ALU_FUN}
  typedef logic [21:0] vec_t;
  vec_t       exp_q[$];
  logic [3:0] h_addr = 4'h0;
  logic [7:0] h_data = 8'h00;
  logic [3:0] h_fun  = 4'h0;

  function automatic vec_t obs_vec();
    return {WrEn, RdEn, ALU_EN, enable_alu, enable_reg, CMD_ERR, Address, WrData, ALU_FUN};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
    h_addr = a; h_data = d;
    exp_q.push_back({6'b100000, h_addr, h_data, h_fun});
  endtask

  task automatic exp_rd(input logic [3:0] a);
    h_addr = a;
    exp_q.push_back({6'b010010, h_addr, h_data, h_fun});
  endtask

  task automatic exp_alu(input logic [3:0] f);
    h_fun = f;
    exp_q.push_back({6'b001100, h_addr, h_data, h_fun});
  endtask

  task automatic exp_err();
    exp_q.push_back({6'b000001, h_addr, h_data, h_fun});
  endtask

  // Called at posedge+1; presents one byte for exactly one sampling edge.
  task automatic drive(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    RX_D_VLD = 1'b0;
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic check_gate(input string tag, input logic exp);
    check(tag, {31'd0, CLK_GATE_EN}, {31'd0, exp});
  endtask

  // Any strobe cycle must match the oldest expectation; strobes with nothing queued are errors.
  always @(negedge CLK) begin
    vec_t e;
    if (RST && (WrEn || RdEn || ALU_EN || enable_alu || enable_reg || CMD_ERR)) begin
      check("strobe_exclusive", {31'd0, (WrEn & RdEn) | (WrEn & ALU_EN)}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {26'd0, obs_vec()[21:16]}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_vec", {10'd0, obs_vec()}, {10'd0, e});
      end
    end
  end

  initial begin
    #1;
    check("reset_async_outputs", {9'd0, obs_vec(), CLK_GATE_EN}, 32'd0);
    repeat (2) @(posedge CLK);
    #3 RST = 1'b1;
    @(posedge CLK); #1;
    check("reset_outputs_after_release", {9'd0, obs_vec(), CLK_GATE_EN}, 32'd0);

    // register write
    drive(8'hAA); drive(8'h05); exp_wr(4'h5, 8'h3C); drive(8'h3C);
    idle(2);

    // register read
    drive(8'hBB); exp_rd(4'h7); drive(8'h07);
    idle(2);

    // ALU with operands, clock gate tracked through the sequence
    check_gate("gate_idle", 1'b0);
    drive(8'hCC);
    check_gate("gate_opa", 1'b1);
    exp_wr(4'h0, 8'h12); drive(8'h12);
    check_gate("gate_opb", 1'b1);
    idle(1);
    check_gate("gate_opb_wait", 1'b1);
    exp_wr(4'h1, 8'h34); drive(8'h34);
    check_gate("gate_fn", 1'b1);
    exp_alu(4'h2); drive(8'h02);
    check_gate("gate_alu_en", 1'b1);
    idle(1);
    check_gate("gate_after", 1'b0);
    idle(1);

    // ALU without operands, payload 0xAA; back-to-back read follows
    drive(8'hDD); exp_alu(4'hA); drive(8'hAA);
    drive(8'hBB); exp_rd(4'h3); drive(8'h03);
    idle(2);

    // unknown opcode, then recovery
    exp_err(); drive(8'h55);
    drive(8'hBB); exp_rd(4'h1); drive(8'h01);
    idle(2);

    // opcode-valued payload bytes, address truncated to 4 bits
    drive(8'hAA); drive(8'hCC); exp_wr(4'hC, 8'hDD); drive(8'hDD);
    idle(2);

`ifdef CMD_TIMEOUT_EN
    drive(8'hAA); drive(8'h03);
    idle(15);
    check("tmo_not_yet", {31'd0, CMD_ERR}, 32'd0);
    exp_err(); idle(1);
    check("tmo_err_pulse", {31'd0, CMD_ERR}, 32'd1);
    exp_err(); drive(8'h3C);
    idle(2);
    // byte arriving in the expiry cycle is accepted
    drive(8'hAA); drive(8'h03);
    idle(15);
    exp_wr(4'h3, 8'h3C); drive(8'h3C);
    idle(2);
`else
    drive(8'hAA); drive(8'h03);
    idle(40);
    check("no_timeout_err", {31'd0, CMD_ERR}, 32'd0);
    exp_wr(4'h3, 8'h3C); drive(8'h3C);
    idle(2);
`endif

    // reset in the middle of an ALU command
    drive(8'hCC); exp_wr(4'h0, 8'h11); drive(8'h11);
    idle(1);
    #2 RST = 1'b0;
    #1;
    check("reset_mid_cmd", {9'd0, obs_vec(), CLK_GATE_EN}, 32'd0);
    h_addr = 4'h0; h_data = 8'h00; h_fun = 4'h0;
    @(posedge CLK);
    #3 RST = 1'b1;
    @(posedge CLK); #1;
    exp_err(); drive(8'h22);
    idle(3);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
